ss_spi_shift: RTL and testbench
===============================

SS_SPI_SHIFT -- requirements
Module: ss_spi_shift

Interface
REQ-001 Parameter CLK_DIV, default 4, sets the SPI half-period in wb_clk_i cycles; legal range is 1..255 and any other value SHALL be an elaboration error.
REQ-002 Port wb_clk_i  in  1  sole clock; all state SHALL be registered on its rising edge.
REQ-003 Port wb_rst_i  in  1  reset; it is synchronous and active-high.
REQ-004 Port tx_valid  in  1  the byte source offers a byte.
REQ-005 Port tx_data  in  8  byte to shift out.
REQ-006 Port tx_last  in  1  deassert select after this byte.
REQ-007 Port tx_ready  out  1  byte accepted when tx_valid and tx_ready are both high.
REQ-008 Port abort  in  1  terminate the current transfer immediately.
REQ-009 Port rx_valid  out  1  one-cycle pulse; rx_data is valid.
REQ-010 Port rx_data  out  8  byte sampled from spi_di_i.
REQ-011 Port busy  out  1  high in every state except IDLE.
REQ-012 Ports spi_clk_o, spi_sel_o (active-low), spi_do_o, spi_do_en, spi_en  out  1 each; spi_di_i  in  1.
REQ-013 Ports spi_di_en and spi_di_o  out  1 each; both SHALL be tied to 0.

Function
REQ-014 SPI mode 0: spi_clk_o SHALL idle low, spi_di_i SHALL be sampled on each rising spi_clk_o edge, and spi_do_o SHALL change only on falling edges or in SETUP.
REQ-015 The sub-module SHALL generate a one-cycle tick every CLK_DIV cycles, and its counter SHALL restart at 0 on entry to SETUP.
REQ-016 FSM states SHALL be IDLE, SETUP, SHIFT, GAP and HOLD.
REQ-017 IDLE: tx_ready=1; on accept, load the shift register and the last flag, then go to SETUP.
REQ-018 SETUP: spi_sel_o=0 and spi_do_o=first bit; it lasts CLK_DIV cycles, then goes to SHIFT.
REQ-019 SHIFT: spi_clk_o SHALL toggle on each tick, for 16 ticks total (8 bits); after the last tick spi_clk_o SHALL be 0.
REQ-020 On SHIFT exit, rx_valid=1 for exactly one cycle with rx_data; rx_valid SHALL assert exactly 1+17*CLK_DIV cycles after the accepting edge.
REQ-021 SHIFT exit with last=1 SHALL go to HOLD; with last=0 it SHALL go to GAP.
REQ-022 GAP: spi_sel_o stays 0 and tx_ready=1; on accept, go to SETUP; it may wait indefinitely.
REQ-023 HOLD: spi_sel_o stays 0 for CLK_DIV cycles; then spi_sel_o=1 and the FSM returns to IDLE.
REQ-024 tx_ready SHALL be 0 in SETUP, SHIFT and HOLD.
REQ-025 spi_do_en and spi_en SHALL equal !spi_sel_o.
REQ-026 abort in any non-IDLE state: the next cycle SHALL be IDLE with spi_sel_o=1 and spi_clk_o=0, and no rx_valid SHALL be produced.
REQ-027 abort in IDLE SHALL have no effect.
REQ-028 abort and an accept in the same cycle: abort SHALL win and the byte SHALL be dropped, with tx_ready forced to 0 while abort=1.
REQ-029 rx_valid has no backpressure; the consumer SHALL take it in the same cycle.

Reset
REQ-030 While wb_rst_i=1 the block SHALL hold the reset values below; the next edge after deassertion SHALL begin in IDLE.
REQ-031 Reset values: state=IDLE, spi_sel_o=1, spi_clk_o=0, spi_do_o=0, spi_do_en=0, spi_en=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, divider=0.
REQ-032 tx_ready SHALL rise on the first cycle after reset release.
REQ-033 Reset asserted mid-transfer SHALL abandon the byte silently.

Configuration
REQ-034 With SS_SPI_LSB_FIRST_EN defined, bit 0 SHALL be shifted out first and the first sampled bit SHALL land in rx_data[0].
REQ-035 Without SS_SPI_LSB_FIRST_EN, the block SHALL be MSB-first on both directions.
REQ-036 SS_SPI_LSB_FIRST_EN SHALL have no effect on timing.

Structure
REQ-037 Package ss_spi_pkg SHALL hold the FSM state enumeration, the default CLK_DIV, and the 16 half-period count constant.
REQ-038 The tick generator SHALL be a single sub-module, ss_spi_clkdiv (CLK_DIV parameter; inputs clear and enable; output tick).

Verification
REQ-039 CLK_DIV=2, spi_di_i looped to spi_do_o, send 0xA5 with last=1 -> rx_data=0xA5 and rx_valid exactly 35 cycles after accept; spi_sel_o rises 2 cycles after rx_valid.
REQ-040 CLK_DIV=1, send 0x3C (last=0) then 0xC3 (last=1), loopback -> two rx_valid pulses 0x3C and 0xC3; spi_sel_o stays 0 between them; exactly 16 rising spi_clk_o edges.
REQ-041 CLK_DIV=4, spi_di_i held at 1, send 0x00 -> rx_data=0xFF; spi_do_o stays 0 throughout.
REQ-042 Assert abort during the 5th spi_clk_o high phase -> the next cycle shows spi_sel_o=1, spi_clk_o=0, busy=0; no rx_valid.
REQ-043 Assert wb_rst_i during SHIFT -> all outputs hold the reset values of REQ-031; tx_ready=1 on the first cycle after release.
REQ-044 SS_SPI_LSB_FIRST_EN defined, send 0x01, spi_di_i held low -> spi_do_o is 1 during the first bit, and rx_data=0x00.

Source files
------------

// File: rtl/ss_spi_pkg.sv
// rtl/ss_spi_pkg.sv - FSM states, constants and bit-order helpers (SS_SPI_LSB_FIRST_EN selects LSB-first)
package ss_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_HOLD
  } state_e;

  localparam int         DEFAULT_CLK_DIV = 4;
  localparam logic [4:0] HALF_PERIODS    = 5'd16;

  function automatic logic first_bit(input logic [7:0] v);
`ifdef SS_SPI_LSB_FIRST_EN
    return v[0];
`else
    return v[7];
`endif
  endfunction

  function automatic logic [7:0] shift_out(input logic [7:0] v);
`ifdef SS_SPI_LSB_FIRST_EN
    return v >> 1;
`else
    return v << 1;
`endif
  endfunction

  function automatic logic [7:0] shift_in(input logic [7:0] v, input logic b);
`ifdef SS_SPI_LSB_FIRST_EN
    return {b, v[7:1]};
`else
    return {v[6:0], b};
`endif
  endfunction

endpackage

// File: rtl/ss_spi_clkdiv.sv
// rtl/ss_spi_clkdiv.sv - one-cycle tick every CLK_DIV enabled cycles, restartable via clear
module ss_spi_clkdiv #(
  parameter int CLK_DIV = 4
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ss_spi_shift.sv
// rtl/ss_spi_shift.sv - SPI mode-0 byte shifter with select framing; SS_SPI_LSB_FIRST_EN selects LSB-first
module ss_spi_shift
  import ss_spi_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  input  logic       abort,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       spi_clk_o,
  output logic       spi_sel_o,
  output logic       spi_do_o,
  output logic       spi_do_en,
  output logic       spi_en,
  input  logic       spi_di_i,
  output logic       spi_di_en,
  output logic       spi_di_o
);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("ss_spi_shift: CLK_DIV must be within 1..255");
  end

  state_e     state_q, state_d;
  logic       sel_q, sel_d, clk_q, clk_d, do_q, do_d;
  logic       last_q, last_d, ready_q, ready_d, rx_valid_q, rx_valid_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [4:0] half_q, half_d;
  logic       accept, tick, div_clear, div_enable;

  assign tx_ready   = ready_q & ~abort;
  assign accept     = tx_valid & tx_ready;
  assign div_enable = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

  ss_spi_clkdiv #(
    .CLK_DIV(CLK_DIV)
  ) u_clkdiv (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .clear   (div_clear),
    .enable  (div_enable),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    clk_d      = clk_q;
    do_d       = do_q;
    last_d     = last_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    half_d     = half_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    ready_d    = 1'b0;
    div_clear  = 1'b0;
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      sel_d   = 1'b1;
      clk_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_GAP: begin
          if (accept) begin
            state_d   = ST_SETUP;
            sel_d     = 1'b0;
            tx_sh_d   = tx_data;
            do_d      = first_bit(tx_data);
            last_d    = tx_last;
            half_d    = '0;
            div_clear = 1'b1;
          end
        end
        ST_SETUP: begin
          if (tick) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          // One settle cycle after the 16th half-period, then publish the byte.
          if (half_q == HALF_PERIODS) begin
            state_d    = last_q ? ST_HOLD : ST_GAP;
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_q;
            div_clear  = 1'b1;
          end else if (tick) begin
            half_d = half_q + 5'd1;
            clk_d  = ~clk_q;
            if (!clk_q) begin
              rx_sh_d = shift_in(rx_sh_q, spi_di_i);
            end else if (half_q != HALF_PERIODS - 5'd1) begin
              tx_sh_d = shift_out(tx_sh_q);
              do_d    = first_bit(tx_sh_d);
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state_d = ST_IDLE;
            sel_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    ready_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b1;
      clk_q      <= 1'b0;
      do_q       <= 1'b0;
      last_q     <= 1'b0;
      ready_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      half_q     <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      clk_q      <= clk_d;
      do_q       <= do_d;
      last_q     <= last_d;
      ready_q    <= ready_d;
      rx_valid_q <= rx_valid_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      half_q     <= half_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign spi_clk_o = clk_q;
  assign spi_sel_o = sel_q;
  assign spi_do_o  = do_q;
  assign spi_do_en = ~sel_q;
  assign spi_en    = ~sel_q;
  assign spi_di_en = 1'b0;
  assign spi_di_o  = 1'b0;

endmodule

// File: tb/tb_ss_spi_shift.sv
// tb/tb_ss_spi_shift.sv - self-checking bench for ss_spi_shift at CLK_DIV 1, 2 and 4
module tb_ss_spi_shift;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] tx_valid = '0, tx_last = '0, abort_i = '0, di_drv = '0, loop_en = '0;
  logic [7:0] tx_data [3];
  logic [7:0] rx_data [3];
  wire  [2:0] tx_ready, rx_valid, busy, sclk, sel, sdo, sdo_en, sen, sdi_en, sdi_o, sdi;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  assign sdi = (loop_en & sdo) | (~loop_en & di_drv);

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ss_spi_shift #(
      .CLK_DIV(g == 0 ? 1 : (g == 1 ? 2 : 4))
    ) u_dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .tx_valid (tx_valid[g]),
      .tx_data  (tx_data[g]),
      .tx_last  (tx_last[g]),
      .tx_ready (tx_ready[g]),
      .abort    (abort_i[g]),
      .rx_valid (rx_valid[g]),
      .rx_data  (rx_data[g]),
      .busy     (busy[g]),
      .spi_clk_o(sclk[g]),
      .spi_sel_o(sel[g]),
      .spi_do_o (sdo[g]),
      .spi_do_en(sdo_en[g]),
      .spi_en   (sen[g]),
      .spi_di_i (sdi[g]),
      .spi_di_en(sdi_en[g]),
      .spi_di_o (sdi_o[g])
    );
  end

  function automatic int div_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  // Position in the byte of the i-th bit on the wire.
  function automatic int bidx(input int i);
`ifdef SS_SPI_LSB_FIRST_EN
    return i;
`else
    return 7 - i;
`endif
  endfunction

  task automatic accept_byte(input int k, input logic [7:0] b, input logic last, output bit ok);
    ok = 1'b0;
    tx_data[k] = b;
    tx_last[k] = last;
    tx_valid[k] = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      #1;
      ok = tx_ready[k];
      @(negedge clk);
    end
    tx_valid[k] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout inst%0d: tx_ready stayed 0, required 1", k);
    end
  endtask

  task automatic send_byte(input int k, input logic [7:0] b, input logic last, input logic [7:0] dpat,
                           output logic [7:0] got, output logic [7:0] dobits, output int lat,
                           output int nrise, output int selhi, output logic doany);
    bit   ok;
    logic prev;
    got = '0; dobits = '0; lat = -1; nrise = 0; selhi = 0; doany = 1'b0; prev = 1'b0;
    di_drv[k] = dpat[bidx(0)];
    accept_byte(k, b, last, ok);
    for (int c = 0; c < 100 && ok && lat < 0; c++) begin
      if (sclk[k] && !prev) begin
        if (nrise < 8) dobits[bidx(nrise)] = sdo[k];
        nrise++;
        if (nrise < 8) di_drv[k] = dpat[bidx(nrise)];
      end
      prev  = sclk[k];
      selhi += int'(sel[k]);
      doany |= sdo[k];
      if (rx_valid[k]) begin
        got = rx_data[k];
        lat = c;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL rx_timeout inst%0d: no rx_valid, required one", k);
    end
  endtask

  task automatic wait_sel(input int k, output int n);
    n = 0;
    while (!sel[k] && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_rises(input int k, input int target, output bit ok);
    int   nr = 0;
    logic prev = sclk[k];
    for (int c = 0; c < 200 && nr < target; c++) begin
      @(negedge clk);
      if (sclk[k] && !prev) nr++;
      prev = sclk[k];
    end
    ok = (nr == target);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rise_timeout inst%0d: saw %0d spi_clk rises, required %0d", k, nr, target);
    end
  endtask

  task automatic check_reset_outputs(input int k, input string tag);
    logic [9:0] v;
    v = {sel[k], sclk[k], sdo[k], sdo_en[k], sen[k], tx_ready[k], rx_valid[k], busy[k], sdi_en[k], sdi_o[k]};
    checks++;
    if (v !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL %s_outputs inst%0d: got %b, required 1000000000", tag, k, v);
    end
    checks++;
    if (rx_data[k] !== 8'h00) begin
      errors++;
      $display("FAIL %s_rx_data inst%0d: got %h, required 00", tag, k, rx_data[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check_reset_outputs(k, "reset");
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 3'b111 || busy !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: tx_ready=%b busy=%b, required 111 000", tx_ready, busy);
    end
  endtask

  task automatic test_loopback_a5();
    logic [7:0] got, dob;
    int lat, nr, sh, n;
    logic da;
    loop_en[1] = 1'b1;
    send_byte(1, 8'hA5, 1'b1, 8'h00, got, dob, lat, nr, sh, da);
    checks++;
    if (got !== 8'hA5) begin errors++; $display("FAIL a5_rx_data: got %h, required a5", got); end
    checks++;
    if (lat != 35) begin errors++; $display("FAIL a5_latency: got %0d, required 35", lat); end
    checks++;
    if (dob !== 8'hA5 || nr != 8 || sh != 0) begin
      errors++;
      $display("FAIL a5_wire: do bits %h rises %0d sel-high %0d, required a5 8 0", dob, nr, sh);
    end
    checks++;
    if ({sdo_en[1], sen[1]} !== 2'b11) begin
      errors++;
      $display("FAIL a5_enables: got %b, required 11", {sdo_en[1], sen[1]});
    end
    wait_sel(1, n);
    checks++;
    if (n != 2) begin errors++; $display("FAIL a5_sel_rise: got %0d cycles, required 2", n); end
    checks++;
    if ({sdo_en[1], sen[1], busy[1]} !== 3'b000) begin
      errors++;
      $display("FAIL a5_after_hold: en/busy %b, required 000", {sdo_en[1], sen[1], busy[1]});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g1, g2, d1, d2;
    int l1, l2, r1, r2, s1, s2, n;
    logic da;
    loop_en[0] = 1'b1;
    send_byte(0, 8'h3C, 1'b0, 8'h00, g1, d1, l1, r1, s1, da);
    @(negedge clk);
    checks++;
    if ({rx_valid[0], sel[0], busy[0]} !== 3'b001) begin
      errors++;
      $display("FAIL b2b_gap: rx_valid/sel/busy %b, required 001", {rx_valid[0], sel[0], busy[0]});
    end
    send_byte(0, 8'hC3, 1'b1, 8'h00, g2, d2, l2, r2, s2, da);
    checks++;
    if (g1 !== 8'h3C || g2 !== 8'hC3) begin
      errors++;
      $display("FAIL b2b_rx_data: got %h %h, required 3c c3", g1, g2);
    end
    checks++;
    if (l1 != 18 || l2 != 18) begin errors++; $display("FAIL b2b_latency: got %0d %0d, required 18 18", l1, l2); end
    checks++;
    if (r1 + r2 != 16 || s1 + s2 != 0) begin
      errors++;
      $display("FAIL b2b_wire: rises %0d sel-high %0d, required 16 0", r1 + r2, s1 + s2);
    end
    wait_sel(0, n);
    checks++;
    if (n != 1) begin errors++; $display("FAIL b2b_sel_rise: got %0d cycles, required 1", n); end
  endtask

  task automatic test_di_high();
    logic [7:0] got, dob;
    int lat, nr, sh, n;
    logic da;
    loop_en[2] = 1'b0;
    send_byte(2, 8'h00, 1'b1, 8'hFF, got, dob, lat, nr, sh, da);
    checks++;
    if (got !== 8'hFF) begin errors++; $display("FAIL dihigh_rx_data: got %h, required ff", got); end
    checks++;
    if (da !== 1'b0 || lat != 69) begin
      errors++;
      $display("FAIL dihigh_do_lat: do seen %b latency %0d, required 0 69", da, lat);
    end
    wait_sel(2, n);
    checks++;
    if (n != 4) begin errors++; $display("FAIL dihigh_sel_rise: got %0d cycles, required 4", n); end
  endtask

  task automatic test_abort();
    bit ok;
    int nrx = 0;
    loop_en[2] = 1'b1;
    accept_byte(2, 8'hFF, 1'b1, ok);
    wait_rises(2, 5, ok);
    abort_i[2] = 1'b1;
    tx_data[2] = 8'h55;
    tx_valid[2] = 1'b1;
    #1;
    checks++;
    if (tx_ready[2] !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b, required 0", tx_ready[2]); end
    @(negedge clk);
    checks++;
    if ({sel[2], sclk[2], busy[2]} !== 3'b100) begin
      errors++;
      $display("FAIL abort_state: sel/clk/busy %b, required 100", {sel[2], sclk[2], busy[2]});
    end
    abort_i[2] = 1'b0;
    tx_valid[2] = 1'b0;
    repeat (100) begin
      @(negedge clk);
      nrx += int'(rx_valid[2]) + int'(busy[2]);
    end
    checks++;
    if (nrx != 0) begin errors++; $display("FAIL abort_quiet: %0d rx_valid/busy cycles, required 0", nrx); end
    abort_i[2] = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({sel[2], busy[2], tx_ready[2]} !== 3'b100) begin
      errors++;
      $display("FAIL abort_idle: sel/busy/ready %b, required 100", {sel[2], busy[2], tx_ready[2]});
    end
    abort_i[2] = 1'b0;
    #1;
    checks++;
    if (tx_ready[2] !== 1'b1) begin errors++; $display("FAIL abort_idle_ready: got %b, required 1", tx_ready[2]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int nrx = 0;
    loop_en[1] = 1'b1;
    accept_byte(1, 8'h96, 1'b1, ok);
    wait_rises(1, 3, ok);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs(1, "midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_ready[1], busy[1]} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_release: ready/busy %b, required 10", {tx_ready[1], busy[1]});
    end
    repeat (80) begin
      @(negedge clk);
      nrx += int'(rx_valid[1]);
    end
    checks++;
    if (nrx != 0) begin errors++; $display("FAIL midreset_quiet: %0d rx_valid pulses, required 0", nrx); end
  endtask

  task automatic test_random();
    logic [7:0] b, dpat, got, dob, exp_rx;
    logic last, loop, da;
    int k, lat, nr, sh, n;
    for (int t = 0; t < 12; t++) begin
      k = $urandom_range(0, 2);
      b = 8'($urandom);
      dpat = 8'($urandom);
      loop = 1'($urandom_range(0, 1));
      last = 1'($urandom_range(0, 1));
      loop_en[k] = loop;
      exp_rx = loop ? b : dpat;
      send_byte(k, b, last, dpat, got, dob, lat, nr, sh, da);
      checks++;
      if (got !== exp_rx || dob !== b) begin
        errors++;
        $display("FAIL rand%0d_data inst%0d: rx %h do %h, required %h %h", t, k, got, dob, exp_rx, b);
      end
      checks++;
      if (lat != 1 + 17 * div_of(k) || sh != 0) begin
        errors++;
        $display("FAIL rand%0d_timing inst%0d: latency %0d sel-high %0d, required %0d 0",
                 t, k, lat, sh, 1 + 17 * div_of(k));
      end
      if (last) begin
        wait_sel(k, n);
        checks++;
        if (n != div_of(k)) begin
          errors++;
          $display("FAIL rand%0d_sel_rise inst%0d: got %0d, required %0d", t, k, n, div_of(k));
        end
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) tx_data[k] = 8'h00;
    test_reset();
    test_loopback_a5();
    test_back_to_back();
    test_di_high();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
